// File: rtl/z2_bus_initiator_pkg.sv
// Shared constants and types for the Zorro II bus-master sequencer.
// Contents: FSM state encodings, default DTACK timeout, bus widths and the
// latched request control payload.
package z2_bus_initiator_pkg;

  localparam int unsigned BM_TIMEOUT_DEFAULT = 64;
  localparam int unsigned BM_ADDR_W          = 23;
  localparam int unsigned BM_DATA_W          = 16;
  localparam int unsigned BM_STATE_W         = 3;

  localparam logic [2:0] BM_IDLE    = 3'd0;
  localparam logic [2:0] BM_ADDR    = 3'd1;
  localparam logic [2:0] BM_ASSERT  = 3'd2;
  localparam logic [2:0] BM_WDS     = 3'd3;
  localparam logic [2:0] BM_WAIT    = 3'd4;
  localparam logic [2:0] BM_TERM    = 3'd5;
  localparam logic [2:0] BM_RECOVER = 3'd6;

  // Direction and byte-lane selection captured when a request is accepted.
  typedef struct packed {
    logic rw;
    logic uds;
    logic lds;
  } bm_ctl_t;

endpackage

// File: rtl/z2_bus_initiator_sync2.sv
// Generic 2-flop synchronizer, asynchronous active-high reset to 0.
// Ports: CLK, RESET, d (asynchronous input), q (synchronized output).
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z2_bus_initiator.sv
// Zorro II / 68000-style bus-master sequencer: runs one AS/UDS/LDS/DTACK
// cycle per accepted request, with a bounded DTACK wait that ends in berr.
// Ports: CLK, RESET (async, active high); request side req/req_addr/req_rw/
// req_uds/req_lds/req_wdata; completion done/rdata/berr; bus side ADDR,
// AS_n, UDS_n, LDS_n, RW, DOUT, DOE, DIN, DTACK_n (asynchronous).
module z2_bus_initiator
  import z2_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BM_TIMEOUT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 req,
  input  logic [BM_ADDR_W-1:0] req_addr,
  input  logic                 req_rw,
  input  logic                 req_uds,
  input  logic                 req_lds,
  input  logic [BM_DATA_W-1:0] req_wdata,
  output logic                 done,
  output logic [BM_DATA_W-1:0] rdata,
  output logic                 berr,
  output logic [BM_ADDR_W-1:0] ADDR,
  output logic                 AS_n,
  output logic                 UDS_n,
  output logic                 LDS_n,
  output logic                 RW,
  output logic [BM_DATA_W-1:0] DOUT,
  output logic                 DOE,
  input  logic [BM_DATA_W-1:0] DIN,
  input  logic                 DTACK_n
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [BM_STATE_W-1:0] st, st_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  bm_ctl_t               ctl, ctl_nx;
  logic [BM_ADDR_W-1:0]  addr_nx;
  logic [BM_DATA_W-1:0]  dout_nx, rdata_nx;
  logic                  as_n_nx, uds_n_nx, lds_n_nx, rw_nx, doe_nx;
  logic                  done_nx, berr_nx;
  logic                  dtack_a, dtk;

  // DTACK synchronizer (active-high after inversion)
  assign dtack_a = ~DTACK_n;

  sync2 #(.WIDTH(1)) u_dtk_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (dtack_a),
    .q     (dtk)
  );

  // Next state plus next value of every registered output
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    ctl_nx   = ctl;
    addr_nx  = ADDR;
    dout_nx  = DOUT;
    rdata_nx = rdata;
    as_n_nx  = 1'b1;
    uds_n_nx = 1'b1;
    lds_n_nx = 1'b1;
    rw_nx    = 1'b1;
    doe_nx   = 1'b0;
    done_nx  = 1'b0;
    berr_nx  = 1'b0;

    case (st)
      BM_IDLE: begin
        if (req) begin
          st_nx   = BM_ADDR;
          ctl_nx  = '{rw: req_rw, uds: req_uds, lds: req_lds};
          addr_nx = req_addr;
          rw_nx   = req_rw;
          doe_nx  = ~req_rw;
          if (!req_rw) dout_nx = req_wdata;
        end
      end
      BM_ADDR: begin
        // reads strobe data lanes together with AS_n, writes one cycle later
        st_nx    = BM_ASSERT;
        cnt_nx   = '0;
        rw_nx    = ctl.rw;
        doe_nx   = ~ctl.rw;
        as_n_nx  = 1'b0;
        uds_n_nx = ~(ctl.rw & ctl.uds);
        lds_n_nx = ~(ctl.rw & ctl.lds);
      end
      BM_ASSERT: begin
        st_nx    = ctl.rw ? BM_WAIT : BM_WDS;
        rw_nx    = ctl.rw;
        doe_nx   = ~ctl.rw;
        as_n_nx  = 1'b0;
        uds_n_nx = ~ctl.uds;
        lds_n_nx = ~ctl.lds;
      end
      BM_WDS: begin
        st_nx    = BM_WAIT;
        rw_nx    = ctl.rw;
        doe_nx   = ~ctl.rw;
        as_n_nx  = 1'b0;
        uds_n_nx = ~ctl.uds;
        lds_n_nx = ~ctl.lds;
      end
      BM_WAIT: begin
        cnt_nx = cnt + CNT_W'(1);
        rw_nx  = ctl.rw;
        doe_nx = ~ctl.rw;
        if (dtk) begin
          st_nx   = BM_TERM;
          done_nx = 1'b1;
          if (ctl.rw) rdata_nx = DIN;
        end else if (cnt == CNT_LAST) begin
          st_nx    = BM_TERM;
          done_nx  = 1'b1;
          berr_nx  = 1'b1;
          rdata_nx = 16'hFFFF;
        end else begin
          as_n_nx  = 1'b0;
          uds_n_nx = ~ctl.uds;
          lds_n_nx = ~ctl.lds;
        end
      end
      BM_TERM: begin
        st_nx = BM_RECOVER;
      end
      BM_RECOVER: begin
        // hold off the next cycle until the target releases DTACK
        if (!dtk) st_nx = BM_IDLE;
      end
      default: begin
        st_nx = BM_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st    <= BM_IDLE;
      cnt   <= '0;
      ctl   <= '0;
      ADDR  <= '0;
      DOUT  <= '0;
      rdata <= '0;
      AS_n  <= 1'b1;
      UDS_n <= 1'b1;
      LDS_n <= 1'b1;
      RW    <= 1'b1;
      DOE   <= 1'b0;
      done  <= 1'b0;
      berr  <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      ctl   <= ctl_nx;
      ADDR  <= addr_nx;
      DOUT  <= dout_nx;
      rdata <= rdata_nx;
      AS_n  <= as_n_nx;
      UDS_n <= uds_n_nx;
      LDS_n <= lds_n_nx;
      RW    <= rw_nx;
      DOE   <= doe_nx;
      done  <= done_nx;
      berr  <= berr_nx;
    end
  end

endmodule

// File: tb/tb_z2_bus_initiator.sv
// Directed bench for z2_bus_initiator (TIMEOUT_CYCLES = 8): read, lane-select
// write with late DTACK, timeout, DTACK held into RECOVER, reset mid-cycle.
module tb_z2_bus_initiator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req;
  logic [22:0] req_addr;
  logic        req_rw, req_uds, req_lds;
  logic [15:0] req_wdata;
  logic        done, berr;
  logic [15:0] rdata;
  logic [22:0] ADDR;
  logic        AS_n, UDS_n, LDS_n, RW, DOE;
  logic [15:0] DOUT;
  logic [15:0] DIN;
  logic        DTACK_n;

  int   checks   = 0;
  int   failures = 0;
  logic seen_done;

  always #5 CLK = ~CLK;

  z2_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_uds   (req_uds),
    .req_lds   (req_lds),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .berr      (berr),
    .ADDR      (ADDR),
    .AS_n      (AS_n),
    .UDS_n     (UDS_n),
    .LDS_n     (LDS_n),
    .RW        (RW),
    .DOUT      (DOUT),
    .DOE       (DOE),
    .DIN       (DIN),
    .DTACK_n   (DTACK_n)
  );

  // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    RESET = 1'b1; req = 1'b0; req_addr = '0; req_rw = 1'b1;
    req_uds = 1'b0; req_lds = 1'b0; req_wdata = '0; DIN = '0; DTACK_n = 1'b1;
    repeat (2) step();

    // reset values
    chk("rst_strobes_rw", 32'({AS_n, UDS_n, LDS_n, RW}), 32'hF);
    chk("rst_doe_done_berr", 32'({DOE, done, berr}), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);

    // read, DTACK already low and synchronized
    RESET = 1'b0; DTACK_n = 1'b0; DIN = 16'hA55A;
    repeat (3) step();
    req = 1'b1; req_addr = 23'h6D0000; req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b1;
    step();
    chk("rd_c1_addr", 32'(ADDR), 32'h6D0000);
    chk("rd_c1_ctl", 32'({AS_n, UDS_n, LDS_n, RW, DOE}), 32'b11110);
    req = 1'b0;
    step();
    chk("rd_c2_strobes", 32'({AS_n, UDS_n, LDS_n}), 32'b000);
    step();
    chk("rd_c3_done", 32'(done), 32'd0);
    step();
    chk("rd_c4_done_berr", 32'({done, berr}), 32'b10);
    chk("rd_c4_rdata", 32'(rdata), 32'hA55A);
    chk("rd_c4_strobes", 32'({AS_n, UDS_n, LDS_n}), 32'b111);
    DTACK_n = 1'b1; DIN = 16'h0000;
    step();
    chk("rd_c5_done", 32'(done), 32'd0);
    chk("rd_rdata_hold", 32'(rdata), 32'hA55A);
    repeat (4) step();

    // write, LDS only, DTACK five cycles after AS_n falls
    req = 1'b1; req_addr = 23'h000400; req_rw = 1'b0; req_uds = 1'b0; req_lds = 1'b1;
    req_wdata = 16'h1234;
    step();
    chk("wr_c1_ctl", 32'({AS_n, UDS_n, LDS_n, RW, DOE}), 32'b11101);
    chk("wr_c1_dout", 32'(DOUT), 32'h1234);
    req = 1'b0;
    step();
    chk("wr_c2_as", 32'({AS_n, UDS_n, LDS_n, DOE}), 32'b0111);
    step();
    chk("wr_c3_lds", 32'({AS_n, UDS_n, LDS_n, DOE}), 32'b0101);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wr_wait_hold", 32'({AS_n, UDS_n, LDS_n, DOE, done}), 32'b01010);
    end
    DTACK_n = 1'b0;
    step();
    chk("wr_sync1", 32'(done), 32'd0);
    step();
    chk("wr_sync2", 32'({done, AS_n}), 32'b00);
    step();
    chk("wr_done_berr", 32'({done, berr}), 32'b10);
    chk("wr_term", 32'({AS_n, UDS_n, LDS_n, DOE, RW}), 32'b11110);
    DTACK_n = 1'b1;
    step();
    chk("wr_recover", 32'({DOE, RW, done}), 32'b010);
    repeat (4) step();

    // timeout: no DTACK, UDS only
    req = 1'b1; req_addr = 23'h0ABCDE; req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b0;
    DIN = 16'h1111;
    step();
    req = 1'b0;
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to_wait", 32'({AS_n, UDS_n, LDS_n, done}), 32'b0010);
    end
    step();
    chk("to_done_berr", 32'({done, berr}), 32'b11);
    chk("to_rdata", 32'(rdata), 32'hFFFF);
    chk("to_strobes", 32'({AS_n, UDS_n, LDS_n}), 32'b111);
    req = 1'b1; req_addr = 23'h000123; req_lds = 1'b1;
    step();
    chk("to_recover_addr", 32'(ADDR), 32'h0ABCDE);
    step();
    chk("to_idle_addr", 32'(ADDR), 32'h0ABCDE);
    step();
    chk("to_next_addr", 32'(ADDR), 32'h000123);
    req = 1'b0;
    wait_done("to2_wait", 20);
    chk("to2_berr", 32'(berr), 32'd1);
    repeat (3) step();

    // target holds DTACK four cycles after AS_n rises, req held high
    DTACK_n = 1'b0; DIN = 16'hBEEF;
    repeat (3) step();
    req = 1'b1; req_addr = 23'h000200; req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b1;
    repeat (4) step();
    chk("hd_done_berr", 32'({done, berr}), 32'b10);
    chk("hd_rdata", 32'(rdata), 32'hBEEF);
    req_addr = 23'h000300; DIN = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hd_stall", 32'({ADDR, AS_n}), 32'({23'h000200, 1'b1}));
    end
    DTACK_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hd_sync_stall", 32'({ADDR, AS_n}), 32'({23'h000200, 1'b1}));
    end
    step();
    chk("hd_next_addr", 32'(ADDR), 32'h000300);
    req = 1'b0; DTACK_n = 1'b0;
    wait_done("hd2_wait", 10);
    chk("hd2_berr", 32'(berr), 32'd0);
    chk("hd2_rdata", 32'(rdata), 32'h0F0F);
    DTACK_n = 1'b1;
    repeat (5) step();

    // reset asserted in WAIT of a write
    req = 1'b1; req_addr = 23'h000555; req_rw = 1'b0; req_uds = 1'b1; req_lds = 1'b1;
    req_wdata = 16'hCAFE;
    step();
    req = 1'b0;
    repeat (3) step();
    chk("rs_wait", 32'({AS_n, UDS_n, LDS_n, DOE}), 32'b0001);
    step();
    RESET = 1'b1;
    #1;
    chk("rs_async", 32'({AS_n, UDS_n, LDS_n, DOE, done}), 32'b11100);
    step();
    RESET = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen_done = seen_done | done;
    end
    chk("rs_no_done", 32'({seen_done, AS_n}), 32'b01);
    DTACK_n = 1'b0; DIN = 16'h5AA5;
    repeat (3) step();
    req = 1'b1; req_addr = 23'h000777; req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b1;
    step();
    req = 1'b0;
    wait_done("rs_next_wait", 8);
    chk("rs_next_berr", 32'(berr), 32'd0);
    chk("rs_next_rdata", 32'(rdata), 32'h5AA5);
    DTACK_n = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
